edge_window_feeder: RTL

Upstream stage of the `matrix_el` array. Accepts a stream of graph edges (source/destination node IDs) over a valid/ready handshake and buffers them in a small FIFO. Serialises each edge into a probe cycle and a store cycle on the broadcast bus that the matrix elements consume. Maintains the circular window write pointer (`edge_addr`) and window occupancy, so slot reuse is consistent across all elements.

---
 rtl/edge_window_feeder.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/edge_window_feeder.sv
// edge_window_feeder: FIFO-buffered edge serialiser (probe/settle/store) with circular window pointer; macro EDGE_FEEDER_IDCHK_EN adds ID range drop.
// Accept at edge N -> data_rdy in cycle N+2, edge_rdy in N+4; backpressure via in_ready = !fifo_full.

module edge_window_fifo #(
  parameter int WIDTH = 22,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  // A push into a full FIFO is fine when the same cycle frees a slot.
  assign push_ok = push && (!full || pop_ok);
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module edge_window_feeder #(
  parameter int WINSIZE    = 200,
  parameter int POPSIZE    = 100,
  parameter int ID_WIDTH   = 11,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [ID_WIDTH-1:0]          in_src,
  input  logic [ID_WIDTH-1:0]          in_dst,
  input  logic                         win_clr,
  output logic [ID_WIDTH-1:0]          edge_out,
  output logic [$clog2(WINSIZE)-1:0]   edge_addr,
  output logic                         data_rdy,
  output logic                         edge_rdy,
  output logic [$clog2(WINSIZE+1)-1:0] win_count,
  output logic                         win_full,
  output logic                         id_err,
  output logic                         busy
);
  localparam int AW = $clog2(WINSIZE);
  localparam int CW = $clog2(WINSIZE + 1);

`ifdef EDGE_FEEDER_IDCHK_EN
  localparam bit IDCHK = 1'b1;
`else
  localparam bit IDCHK = 1'b0;
`endif

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_PROBE  = 2'd1;
  localparam logic [1:0] S_SETTLE = 2'd2;
  localparam logic [1:0] S_STORE  = 2'd3;

  typedef struct packed {
    logic [ID_WIDTH-1:0] src;
    logic [ID_WIDTH-1:0] dst;
  } edge_t;

  logic [1:0]        state;
  edge_t             hold;
  edge_t             head;
  logic [AW-1:0]     wr_ptr;
  logic [CW-1:0]     win_cnt;
  logic              clr_pend;
  logic              clr_now;
  logic              accept;
  logic              id_bad;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [2*ID_WIDTH-1:0] fifo_dat;
  logic              pop_slot;

  assign in_ready  = !rst && !fifo_full;
  assign accept    = in_valid && in_ready;
  assign id_bad    = IDCHK && ((in_src >= ID_WIDTH'(POPSIZE)) || (in_dst >= ID_WIDTH'(POPSIZE)));
  assign fifo_push = accept && !id_bad;
  assign head      = fifo_dat;

  // A new edge can only be taken when the bus is free: from IDLE or as STORE finishes.
  assign pop_slot  = (state == S_IDLE) || (state == S_STORE);
  assign fifo_pop  = pop_slot && !fifo_empty;
  assign clr_now   = win_clr || clr_pend;

  edge_window_fifo #(
    .WIDTH (2 * ID_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .push_dat ({in_src, in_dst}),
    .pop      (fifo_pop),
    .pop_dat  (fifo_dat),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      hold  <= '0;
    end else begin
      case (state)
        S_PROBE:  state <= S_SETTLE;
        S_SETTLE: state <= S_STORE;
        default: begin
          if (fifo_pop) begin
            hold  <= head;
            state <= S_PROBE;
          end else begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

  // Clears land only between edges, so an in-flight edge always stores at the old pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      win_cnt  <= '0;
      clr_pend <= 1'b0;
    end else if (pop_slot && clr_now) begin
      wr_ptr   <= '0;
      win_cnt  <= '0;
      clr_pend <= 1'b0;
    end else begin
      clr_pend <= clr_pend || win_clr;
      if (state == S_STORE) begin
        wr_ptr <= (wr_ptr == AW'(WINSIZE - 1)) ? '0 : wr_ptr + AW'(1);
        if (win_cnt != CW'(WINSIZE)) win_cnt <= win_cnt + CW'(1);
      end
    end
  end

  // Registered bus: every output trails the FSM by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_out  <= '0;
      edge_addr <= '0;
      data_rdy  <= 1'b0;
      edge_rdy  <= 1'b0;
      win_count <= '0;
      win_full  <= 1'b0;
      id_err    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_PROBE, S_SETTLE: edge_out <= hold.src;
        S_STORE:           edge_out <= hold.dst;
        default:           edge_out <= edge_out;
      endcase
      edge_addr <= wr_ptr;
      data_rdy  <= (state == S_PROBE);
      edge_rdy  <= (state == S_STORE);
      win_count <= win_cnt;
      win_full  <= (win_cnt == CW'(WINSIZE));
      id_err    <= accept && id_bad;
      busy      <= (state != S_IDLE) || !fifo_empty;
    end
  end
endmodule
